// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and
// the MEM stage, with data given fixed priority and a pipeline stall output.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [1:0]    owner
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [3:0] LAT      = 4'(MEM_LAT);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          acc_we, acc_we_nxt;
  logic [1:0]    owner_nxt;
  logic          mem_en_nxt, mem_we_nxt, if_ack_nxt, d_ack_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      acc_we    <= 1'b0;
      owner     <= OWN_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc_we    <= acc_we_nxt;
      owner     <= owner_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      if_ack    <= if_ack_nxt;
      d_ack     <= d_ack_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

  // A requester whose ack is high this cycle is not eligible, which lets the
  // other side in during the ack cycle and prevents starvation of fetch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_we_nxt    = acc_we;
    owner_nxt     = owner;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    case (state)
      IDLE: begin
        if (d_req && !d_ack) begin
          state_nxt     = BUSY;
          owner_nxt     = OWN_D;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = d_we;
          acc_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          cnt_nxt       = LAT;
        end else if (if_req && !if_ack) begin
          state_nxt    = BUSY;
          owner_nxt    = OWN_IF;
          mem_en_nxt   = 1'b1;
          acc_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
          cnt_nxt      = LAT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
          if (owner == OWN_D) begin
            d_ack_nxt = 1'b1;
            if (!acc_we) d_rdata_nxt = mem_rdata;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// schedule model: each grant fixes its strobe cycle and ack cycle arithmetically.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          gap;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall;
  logic [1:0]  owner;

  logic        if_req1 = 1'b0;
  logic [31:0] if_addr1 = '0, mem_rdata1 = '0, zero32 = '0;
  logic        zero1 = 1'b0;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, stall1;
  logic [1:0]  owner1;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall(stall1), .owner(owner1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model state: the current/last access and the values the DUT must hold.
  int          cyc;
  bit          has_acc;
  int          en_cyc, ack_cyc, acc_who;
  bit          acc_we;
  logic [31:0] acc_rd;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
  bit          last_ifack, last_dack;
  logic [31:0] mem_model [logic [31:0]];

  req_t if_q[$];
  req_t d_q[$];
  bit   if_act, d_act;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    if (mem_model.exists(addr)) return mem_model[addr];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic modelReset();
    has_acc = 0; en_cyc = 0; ack_cyc = 0; acc_who = 0; acc_we = 0; acc_rd = '0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    last_ifack = 0; last_dack = 0;
    if_act = 0; d_act = 0;
    if_q.delete(); d_q.delete();
    if_req = 1'b0; d_req = 1'b0;
    cyc = 0;
  endtask

  // Requesters: drop a request after its ack, then raise the next queued one.
  task automatic applyStimulus();
    if (if_act && last_ifack) begin
      if_act = 0; if_req = 1'b0; void'(if_q.pop_front());
    end
    if (d_act && last_dack) begin
      d_act = 0; d_req = 1'b0; void'(d_q.pop_front());
    end
    if (!if_act) begin
      if_addr = $urandom();
      if (if_q.size() > 0) begin
        if (if_q[0].gap > 0) if_q[0].gap = if_q[0].gap - 1;
        else begin if_act = 1; if_req = 1'b1; if_addr = if_q[0].addr; end
      end
    end
    if (!d_act) begin
      d_addr = $urandom(); d_wdata = $urandom(); d_we = 1'($urandom_range(0, 1));
      if (d_q.size() > 0) begin
        if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
        else begin
          d_act = 1; d_req = 1'b1;
          d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
        end
      end
    end
  endtask

  // One clock cycle: predict, drive memory data, check at negedge, then grant.
  task automatic runCycle();
    bit busy, e_ifack, e_dack, e_en, e_we, e_stall;
    logic [1:0] e_owner;
    busy    = has_acc && (cyc < ack_cyc);
    e_ifack = has_acc && acc_who == 1 && cyc == ack_cyc;
    e_dack  = has_acc && acc_who == 2 && cyc == ack_cyc;
    if (e_ifack) e_if_rdata = acc_rd;
    if (e_dack && !acc_we) e_d_rdata = acc_rd;
    mem_rdata = (busy && cyc == en_cyc + LAT) ? acc_rd : $urandom();
    e_en    = busy && cyc == en_cyc;
    e_we    = e_en && acc_we;
    e_owner = busy ? 2'(acc_who) : 2'b00;
    e_stall = (if_req && !e_ifack) || (d_req && !e_dack);
    @(negedge clk);
    checkOutput($sformatf("c%0d if_ack", cyc), 32'(if_ack), 32'(e_ifack));
    checkOutput($sformatf("c%0d d_ack", cyc), 32'(d_ack), 32'(e_dack));
    checkOutput($sformatf("c%0d mem_en", cyc), 32'(mem_en), 32'(e_en));
    checkOutput($sformatf("c%0d mem_we", cyc), 32'(mem_we), 32'(e_we));
    checkOutput($sformatf("c%0d owner", cyc), 32'(owner), 32'(e_owner));
    checkOutput($sformatf("c%0d stall", cyc), 32'(stall), 32'(e_stall));
    checkOutput($sformatf("c%0d mem_addr", cyc), mem_addr, e_mem_addr);
    checkOutput($sformatf("c%0d mem_wdata", cyc), mem_wdata, e_mem_wdata);
    checkOutput($sformatf("c%0d if_rdata", cyc), if_rdata, e_if_rdata);
    checkOutput($sformatf("c%0d d_rdata", cyc), d_rdata, e_d_rdata);
    if (!busy) begin
      if (d_req && !e_dack) begin
        has_acc = 1; acc_who = 2; acc_we = d_we;
        en_cyc = cyc + 1; ack_cyc = cyc + 2 + LAT;
        e_mem_addr = d_addr; e_mem_wdata = d_wdata;
        if (d_we) begin mem_model[d_addr] = d_wdata; acc_rd = $urandom(); end
        else acc_rd = memRead(d_addr);
      end else if (if_req && !e_ifack) begin
        has_acc = 1; acc_who = 1; acc_we = 0;
        en_cyc = cyc + 1; ack_cyc = cyc + 2 + LAT;
        e_mem_addr = if_addr;
        acc_rd = memRead(if_addr);
      end
    end
    last_ifack = e_ifack;
    last_dack  = e_dack;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic runUntilIdle(input int budget);
    int n;
    bit done;
    n = 0;
    while ((if_act || d_act || if_q.size() > 0 || d_q.size() > 0 ||
            (has_acc && cyc <= ack_cyc)) && n < budget) begin
      runCycle();
      applyStimulus();
      n++;
    end
    done = !(if_act || d_act || if_q.size() > 0 || d_q.size() > 0);
    checkOutput("drain", 32'(done), 32'd1);
  endtask

  initial begin
    req_t r;
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst owner", 32'(owner), 32'd0);
    checkOutput("rst mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst d_rdata", d_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // MEM_LAT=1 fetch on the second instance.
    if_req1 = 1'b1; if_addr1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      mem_rdata1 = (k == 2) ? 32'h1234_5678 : $urandom();
      @(negedge clk);
      checkOutput($sformatf("lat1 k%0d mem_en", k), 32'(mem_en1), 32'(k == 1));
      checkOutput($sformatf("lat1 k%0d if_ack", k), 32'(if_ack1), 32'(k == 3));
      if (k == 1) checkOutput("lat1 mem_addr", mem_addr1, 32'h200);
      if (k == 3) checkOutput("lat1 if_rdata", if_rdata1, 32'h1234_5678);
      @(posedge clk); #1;
      if (k == 3) if_req1 = 1'b0;
    end

    modelReset();
    mem_model[32'h40] = 32'hDEAD_BEEF;
    // Single load.
    r = '{gap: 0, we: 1'b0, addr: 32'h40, wdata: 32'h0};
    d_q.push_back(r);
    applyStimulus();
    runUntilIdle(20);
    checkOutput("load d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Simultaneous fetch and store.
    r = '{gap: 0, we: 1'b0, addr: 32'h100, wdata: 32'h0};
    if_q.push_back(r);
    r = '{gap: 0, we: 1'b1, addr: 32'h8, wdata: 32'h55};
    d_q.push_back(r);
    applyStimulus();
    runUntilIdle(30);

    // Back-to-back fetches.
    r = '{gap: 0, we: 1'b0, addr: 32'h0, wdata: 32'h0};
    if_q.push_back(r);
    r.addr = 32'h4;
    if_q.push_back(r);
    applyStimulus();
    runUntilIdle(30);

    // Reset in the middle of a load.
    r = '{gap: 0, we: 1'b0, addr: 32'h8, wdata: 32'h0};
    d_q.push_back(r);
    applyStimulus();
    runCycle(); applyStimulus();
    runCycle(); applyStimulus();
    #2;
    rst = 1'b1; d_req = 1'b0; if_req = 1'b0;
    #1;
    checkOutput("mid-rst owner", 32'(owner), 32'd0);
    checkOutput("mid-rst mem_en", 32'(mem_en), 32'd0);
    checkOutput("mid-rst mem_addr", mem_addr, 32'd0);
    checkOutput("mid-rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("mid-rst d_rdata", d_rdata, 32'd0);
    checkOutput("mid-rst if_rdata", if_rdata, 32'd0);
    checkOutput("mid-rst stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    modelReset();
    for (int k = 0; k < 5; k++) begin runCycle(); applyStimulus(); end
    r = '{gap: 0, we: 1'b0, addr: 32'h40, wdata: 32'h0};
    d_q.push_back(r);
    applyStimulus();
    runUntilIdle(20);

    // Randomized traffic over a small address window so loads hit stores.
    for (int i = 0; i < 40; i++) begin
      r.gap = int'($urandom_range(0, 4)); r.we = 1'b0;
      r.addr = 32'($urandom_range(0, 15)) << 2; r.wdata = '0;
      if_q.push_back(r);
      r.gap = int'($urandom_range(0, 4)); r.we = 1'($urandom_range(0, 1));
      r.addr = 32'($urandom_range(0, 15)) << 2; r.wdata = $urandom();
      d_q.push_back(r);
    end
    applyStimulus();
    runUntilIdle(3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
